// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer sequencer: keypad BCD entry, 1 s countdown while cooking,
// door interlock and magnetron enable. All outputs come straight from registers.
module microwave_timer_ctrl #(
   parameter int TICKS_PER_SEC = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic       door_closed,
   output logic [3:0] min,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       mag_on,
   output logic       done,
   output logic [2:0] state
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_TERM = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SET   = 3'd1,
      ST_COOK  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    min_q, min_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          mag_q, mag_d;
   logic          done_q, done_d;

   logic          time_nz_s;
   logic          key_ok_s;
   logic          start_ok_s;
   logic          tick_s;
   logic [11:0]   dec_s;

   // One-second BCD decrement with borrow chain ones -> tens (0..5) -> minutes.
   function automatic logic [11:0] bcd_dec(input logic [3:0] m, input logic [3:0] t,
                                           input logic [3:0] o);
      logic [11:0] r;
      if (o != 4'd0) begin
         r = {m, t, o - 4'd1};
      end else if (t != 4'd0) begin
         r = {m, t - 4'd1, 4'd9};
      end else begin
         r = {m - 4'd1, 4'd5, 4'd9};
      end
      return r;
   endfunction

   // Event qualifiers shared by the next-state logic.
   always_comb begin
      time_nz_s  = (min_q != 4'd0) || (tens_q != 4'd0) || (ones_q != 4'd0);
      // A digit is refused when the current ones digit could not become a legal tens digit.
      key_ok_s   = key_valid && (key_digit <= 4'd9) && (ones_q <= 4'd5);
      start_ok_s = start && time_nz_s && door_closed;
      tick_s     = (presc_q == PRESC_TERM);
      dec_s      = bcd_dec(min_q, tens_q, ones_q);
   end

   // Next-state and next-output logic; priority clear > door > stop > start > key.
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      presc_d = presc_q;
      done_d  = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
         min_d   = 4'd0;
         tens_d  = 4'd0;
         ones_d  = 4'd0;
         presc_d = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_SET: begin
               if (stop && (state_q == ST_SET)) begin
                  state_d = ST_IDLE;
                  min_d   = 4'd0;
                  tens_d  = 4'd0;
                  ones_d  = 4'd0;
                  presc_d = '0;
               end else if (start_ok_s) begin
                  state_d = ST_COOK;
                  presc_d = '0;
               end else if (key_ok_s) begin
                  state_d = ST_SET;
                  min_d   = tens_q;
                  tens_d  = ones_q;
                  ones_d  = key_digit;
               end else begin
                  state_d = state_q;
               end
            end
            ST_COOK: begin
               if (!door_closed || stop) begin
                  state_d = ST_PAUSE;
               end else if (tick_s) begin
                  presc_d = '0;
                  {min_d, tens_d, ones_d} = dec_s;
                  if (dec_s == 12'h000) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_COOK;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            ST_PAUSE: begin
               if (stop) begin
                  state_d = ST_IDLE;
                  min_d   = 4'd0;
                  tens_d  = 4'd0;
                  ones_d  = 4'd0;
                  presc_d = '0;
               end else if (start_ok_s) begin
                  state_d = ST_COOK;
                  presc_d = '0;
               end else begin
                  state_d = ST_PAUSE;
               end
            end
            ST_DONE: begin
               // Time is already 0:00 here, so a key press lands as the first digit.
               if (stop) begin
                  state_d = ST_IDLE;
               end else if (key_ok_s) begin
                  state_d = ST_SET;
                  min_d   = tens_q;
                  tens_d  = ones_q;
                  ones_d  = key_digit;
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               min_d   = 4'd0;
               tens_d  = 4'd0;
               ones_d  = 4'd0;
               presc_d = '0;
            end
         endcase
      end
      mag_d = (state_d == ST_COOK);
   end

   // State, time digits, prescaler and output flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         min_q   <= 4'd0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         presc_q <= '0;
         mag_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         presc_q <= presc_d;
         mag_q   <= mag_d;
         done_q  <= done_d;
      end
   end

   assign min      = min_q;
   assign sec_tens = tens_q;
   assign sec_ones = ones_q;
   assign mag_on   = mag_q;
   assign done     = done_q;
   assign state    = state_q;

endmodule
